// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch/decode/execute controller and its decode stage:
// controller states, opcodes, instruction field positions and the decoded control bundle.
package cpu_pkg;

    localparam int unsigned OPW   = 4;
    localparam int unsigned REGW  = 2;
    localparam int unsigned STW   = 2;

    // Controller state encoding (2'b11 is unused and treated as idle)
    localparam logic [STW-1:0] ST_FETCH   = 2'b00;
    localparam logic [STW-1:0] ST_DECODE  = 2'b01;
    localparam logic [STW-1:0] ST_EXECUTE = 2'b10;

    localparam logic [OPW-1:0] OP_NOP  = 4'd0;
    localparam logic [OPW-1:0] OP_ADD  = 4'd1;
    localparam logic [OPW-1:0] OP_SUB  = 4'd2;
    localparam logic [OPW-1:0] OP_AND  = 4'd3;
    localparam logic [OPW-1:0] OP_OR   = 4'd4;
    localparam logic [OPW-1:0] OP_XOR  = 4'd5;
    localparam logic [OPW-1:0] OP_NOT  = 4'd6;
    localparam logic [OPW-1:0] OP_MOV  = 4'd7;
    localparam logic [OPW-1:0] OP_LDI  = 4'd8;
    localparam logic [OPW-1:0] OP_INC  = 4'd9;
    localparam logic [OPW-1:0] OP_DEC  = 4'd10;
    localparam logic [OPW-1:0] OP_HALT = 4'd11;

    // Low field positions; the opcode always occupies the top OPW bits of the word
    localparam int unsigned RD_LSB = 2;
    localparam int unsigned RS_LSB = 0;

    typedef struct packed {
        logic [OPW-1:0] alu_op;
        logic           wr;
        logic           use_imm;
        logic           is_halt;
        logic           is_illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/instr_decode_stage_decoder.sv
// Purely combinational opcode decoder producing the control bundle for one instruction.
module instr_decoder_comb
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] opcode_i,
    output dec_ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV, OP_INC, OP_DEC: begin
                ctrl_o.alu_op = opcode_i;
                ctrl_o.wr     = 1'b1;
            end
            OP_LDI: begin
                ctrl_o.alu_op  = opcode_i;
                ctrl_o.wr      = 1'b1;
                ctrl_o.use_imm = 1'b1;
            end
            OP_HALT: begin
                ctrl_o.alu_op  = opcode_i;
                ctrl_o.is_halt = 1'b1;
            end
            default: ctrl_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: captures the IR, registers decoded fields for the EXECUTE cycle, tracks status, counts retires.
// Build option ILLEGAL_TRAP_EN: opcodes 12..15 trap (set illegal and halted) instead of acting as NOP.
module instr_decode_stage
    import cpu_pkg::*;
#(
    parameter int unsigned IW = 8,
    parameter int unsigned CW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     state,
    input  logic           rom_read_enable,
    input  logic           ir_load,
    input  logic [IW-1:0]  rom_data,
    output logic [IW-1:0]  ir,
    output logic [3:0]     alu_op,
    output logic [1:0]     rd_sel,
    output logic [1:0]     rs_sel,
    output logic [IW-1:0]  imm,
    output logic           use_imm,
    output logic           rf_we,
    output logic           exec_valid,
    output logic           halted,
    output logic           illegal,
    output logic           proto_err,
    output logic [CW-1:0]  retired_cnt
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [IW-1:0]   ir_q, ir_d;
    dec_ctrl_t       dec_q, dec_d;
    logic [REGW-1:0] rd_q, rd_d;
    logic [REGW-1:0] rs_q, rs_d;
    logic [IW-1:0]   imm_q, imm_d;
    logic            pending_q, pending_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;
    logic            proto_q, proto_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    dec_ctrl_t       dec_ctrl_c;
    logic            capture_c;
    logic            proto_ev_c;
    logic            exec_fire_c;
    logic [REGW-1:0] rs_field_c;

    instr_decoder_comb u_decoder (
        .opcode_i (rom_data[IW-1 -: OPW]),
        .ctrl_o   (dec_ctrl_c)
    );

    assign rs_field_c  = rom_data[RS_LSB +: REGW];
    assign capture_c   = ir_load & rom_read_enable & (state == ST_DECODE) & ~halted_q;
    assign proto_ev_c  = ir_load & (~rom_read_enable | (state != ST_DECODE));
    assign exec_fire_c = (state == ST_EXECUTE) & pending_q & ~halted_q;

    // Next-state logic; every register holds unless an event below updates it
    always_comb begin
        ir_d      = ir_q;
        dec_d     = dec_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        imm_d     = imm_q;
        pending_d = pending_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        proto_d   = proto_q;
        cnt_d     = cnt_q;

        if (proto_ev_c) begin
            proto_d   = 1'b1;
            pending_d = 1'b0;
        end

        if (capture_c) begin
            ir_d      = rom_data;
            dec_d     = dec_ctrl_c;
            rd_d      = rom_data[RD_LSB +: REGW];
            rs_d      = rs_field_c;
            imm_d     = IW'(rs_field_c);
            pending_d = 1'b1;
        end

        if (exec_fire_c) begin
            cnt_d = cnt_q + CW'(1);
            if (dec_q.is_halt) begin
                halted_d = 1'b1;
            end
            if (TRAP_EN && dec_q.is_illegal) begin
                illegal_d = 1'b1;
                halted_d  = 1'b1;
            end
        end

        // Any EXECUTE cycle consumes the pending capture, fired or not
        if (state == ST_EXECUTE) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= '0;
            dec_q     <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            imm_q     <= '0;
            pending_q <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            proto_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ir_q      <= ir_d;
            dec_q     <= dec_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            imm_q     <= imm_d;
            pending_q <= pending_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            proto_q   <= proto_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ir          = ir_q;
    assign alu_op      = dec_q.alu_op;
    assign rd_sel      = rd_q;
    assign rs_sel      = rs_q;
    assign imm         = imm_q;
    assign use_imm     = dec_q.use_imm;
    assign exec_valid  = exec_fire_c;
    assign rf_we       = exec_fire_c & dec_q.wr;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign proto_err   = proto_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: vector table, directed corner sequences, random traffic vs reference model.
module tb_instr_decode_stage;

    localparam int unsigned IW = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    state;
    logic          rom_read_enable;
    logic          ir_load;
    logic [IW-1:0] rom_data;
    logic [IW-1:0] ir;
    logic [3:0]    alu_op;
    logic [1:0]    rd_sel;
    logic [1:0]    rs_sel;
    logic [IW-1:0] imm;
    logic          use_imm;
    logic          rf_we;
    logic          exec_valid;
    logic          halted;
    logic          illegal;
    logic          proto_err;
    logic [CW-1:0] retired_cnt;

    instr_decode_stage #(.IW(IW), .CW(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .state           (state),
        .rom_read_enable (rom_read_enable),
        .ir_load         (ir_load),
        .rom_data        (rom_data),
        .ir              (ir),
        .alu_op          (alu_op),
        .rd_sel          (rd_sel),
        .rs_sel          (rs_sel),
        .imm             (imm),
        .use_imm         (use_imm),
        .rf_we           (rf_we),
        .exec_valid      (exec_valid),
        .halted          (halted),
        .illegal         (illegal),
        .proto_err       (proto_err),
        .retired_cnt     (retired_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, in architectural terms
    logic [7:0] m_ir;
    int         m_alu, m_rd, m_rs, m_imm, m_use, m_wr;
    bit         m_pend, m_halt, m_ill, m_proto;
    int         m_cnt;
    logic       s_ev, s_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ir = 8'h00; m_alu = 0; m_rd = 0; m_rs = 0; m_imm = 0; m_use = 0; m_wr = 0;
        m_pend = 0; m_halt = 0; m_ill = 0; m_proto = 0; m_cnt = 0;
    endtask

    task automatic check_regs();
        chk("ir", 32'(ir), 32'(m_ir));
        chk("alu_op", 32'(alu_op), 32'(m_alu));
        chk("rd_sel", 32'(rd_sel), 32'(m_rd));
        chk("rs_sel", 32'(rs_sel), 32'(m_rs));
        chk("imm", 32'(imm), 32'(m_imm));
        chk("use_imm", 32'(use_imm), 32'(m_use));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("proto_err", 32'(proto_err), 32'(m_proto));
        chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
    endtask

    // One controller cycle: comb outputs checked before the edge, registers after it
    task automatic apply(input logic [1:0] st, input logic rre, input logic ld, input logic [7:0] d);
        bit ev_e, prot, cap;
        int op, cur_op;
        state = st; rom_read_enable = rre; ir_load = ld; rom_data = d;
        #1;
        ev_e = (st == 2'b10) && m_pend && !m_halt;
        chk("exec_valid", 32'(exec_valid), 32'(ev_e));
        chk("rf_we", 32'(rf_we), 32'(ev_e && (m_wr != 0)));
        s_ev = exec_valid;
        s_we = rf_we;
        @(posedge clk);
        prot   = ld && (!rre || st != 2'b01);
        cap    = ld && rre && st == 2'b01 && !m_halt;
        cur_op = int'(m_ir) / 16;
        if (prot) begin
            m_proto = 1;
            m_pend  = 0;
        end
        if (cap) begin
            op    = int'(d) / 16;
            m_ir  = d;
            m_alu = (op <= 11) ? op : 0;
            m_wr  = (op >= 1 && op <= 10) ? 1 : 0;
            m_use = (op == 8) ? 1 : 0;
            m_rd  = (int'(d) / 4) % 4;
            m_rs  = int'(d) % 4;
            m_imm = m_rs;
            m_pend = 1;
        end
        if (ev_e) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            if (cur_op == 11) m_halt = 1;
`ifdef ILLEGAL_TRAP_EN
            if (cur_op >= 12) begin
                m_ill  = 1;
                m_halt = 1;
            end
`endif
        end
        if (st == 2'b10) m_pend = 0;
        #1;
        check_regs();
    endtask

    task automatic run_instr(input logic [7:0] d);
        apply(2'b00, 1'b1, 1'b0, 8'h00);
        apply(2'b01, 1'b1, 1'b1, d);
        apply(2'b10, 1'b0, 1'b0, 8'h00);
    endtask

    // Asynchronous reset pulse inside the current cycle; outputs must clear at once
    task automatic rst_pulse();
        reset = 1'b1;
        #1;
        model_reset();
        check_regs();
        chk("rst_exec_valid", 32'(exec_valid), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] instr;
        logic [3:0] e_alu;
        logic [1:0] e_rd;
        logic [1:0] e_rs;
        logic [7:0] e_imm;
        logic       e_use;
        logic       e_we;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h16, 4'd1,  2'd1, 2'd2, 8'h02, 1'b0, 1'b1};
        vecs[1] = '{8'h8B, 4'd8,  2'd2, 2'd3, 8'h03, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 4'd0,  2'd0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h6D, 4'd6,  2'd3, 2'd1, 8'h01, 1'b0, 1'b1};
        vecs[4] = '{8'hA4, 4'd10, 2'd1, 2'd0, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'h9E, 4'd9,  2'd3, 2'd2, 8'h02, 1'b0, 1'b1};

        reset = 1'b1; state = 2'b00; rom_read_enable = 1'b0; ir_load = 1'b0; rom_data = 8'h00;
        model_reset();
        #3;
        check_regs();
        chk("init_exec_valid", 32'(exec_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_instr(vecs[i].instr);
            chk("vec_ir", 32'(ir), 32'(vecs[i].instr));
            chk("vec_alu_op", 32'(alu_op), 32'(vecs[i].e_alu));
            chk("vec_rd_sel", 32'(rd_sel), 32'(vecs[i].e_rd));
            chk("vec_rs_sel", 32'(rs_sel), 32'(vecs[i].e_rs));
            chk("vec_imm", 32'(imm), 32'(vecs[i].e_imm));
            chk("vec_use_imm", 32'(use_imm), 32'(vecs[i].e_use));
            chk("vec_exec_valid", 32'(s_ev), 32'd1);
            chk("vec_rf_we", 32'(s_we), 32'(vecs[i].e_we));
        end
        chk("vec_retired_cnt", 32'(retired_cnt), 32'd6);

        // ir_load without read strobe in DECODE
        apply(2'b00, 1'b1, 1'b0, 8'h00);
        apply(2'b01, 1'b0, 1'b1, 8'h16);
        apply(2'b10, 1'b0, 1'b0, 8'h00);
        chk("proto_set", 32'(proto_err), 32'd1);
        chk("proto_ir_kept", 32'(ir), 32'h9E);
        chk("proto_no_exec", 32'(s_ev), 32'd0);

        // Capture followed by a stray ir_load outside DECODE cancels the pending execute
        apply(2'b01, 1'b1, 1'b1, 8'h27);
        apply(2'b00, 1'b1, 1'b1, 8'h00);
        apply(2'b10, 1'b0, 1'b0, 8'h00);
        chk("proto_pend_ir", 32'(ir), 32'h27);
        chk("proto_pend_no_exec", 32'(s_ev), 32'd0);
        chk("proto_pend_cnt", 32'(retired_cnt), 32'd6);

        // Illegal opcode
        rst_pulse();
        run_instr(8'hF0);
        chk("ill_exec_valid", 32'(s_ev), 32'd1);
        chk("ill_rf_we", 32'(s_we), 32'd0);
        chk("ill_alu_op", 32'(alu_op), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_halted", 32'(halted), 32'd1);
`else
        chk("ill_flag", 32'(illegal), 32'd0);
        chk("ill_halted", 32'(halted), 32'd0);
        run_instr(8'h16);
        chk("ill_next_exec", 32'(s_ev), 32'd1);
        chk("ill_next_cnt", 32'(retired_cnt), 32'd2);
`endif

        // Reset in the EXECUTE cycle of an ADD
        rst_pulse();
        apply(2'b00, 1'b1, 1'b0, 8'h00);
        apply(2'b01, 1'b1, 1'b1, 8'h16);
        state = 2'b10; rom_read_enable = 1'b0; ir_load = 1'b0;
        rst_pulse();
        apply(2'b10, 1'b0, 1'b0, 8'h00);
        chk("rstx_no_we", 32'(s_we), 32'd0);
        chk("rstx_ir", 32'(ir), 32'd0);

        // HALT then a valid ADD fetch
        run_instr(8'hB0);
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_cnt", 32'(retired_cnt), 32'd1);
        run_instr(8'h16);
        chk("halt_ir_kept", 32'(ir), 32'hB0);
        chk("halt_no_exec", 32'(s_ev), 32'd0);
        chk("halt_cnt_frozen", 32'(retired_cnt), 32'd1);

        // Counter wrap at 2^CW-1
        rst_pulse();
        for (int i = 0; i < (1 << CW) - 1; i++) run_instr(8'h00);
        chk("wrap_max", 32'(retired_cnt), 32'((1 << CW) - 1));
        run_instr(8'h35);
        chk("wrap_zero", 32'(retired_cnt), 32'd0);

        // Random traffic against the model
        rst_pulse();
        for (int i = 0; i < 250; i++) begin
            if (m_halt || $urandom_range(0, 24) == 0) begin
                rst_pulse();
            end else if ($urandom_range(0, 3) != 0) begin
                run_instr(8'($urandom));
            end else begin
                apply(2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
